// File: rtl/tt_sweep_capture.sv
// Sweeps all 2^NIN minterms into a combinational function block and captures its truth table.
// Optional TT_POPCOUNT_EN adds an onset output counting minterms with f=1.
module tt_sweep_capture #(
    parameter int NIN = 7,
    parameter int LAT = 0,
    localparam int TT_W = 2 ** NIN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic [NIN-1:0]  x_o,
    input  logic            f_i,
    input  logic [TT_W-1:0] exp_tt,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [TT_W-1:0] tt,
    output logic            mismatch
`ifdef TT_POPCOUNT_EN
    ,
    output logic [NIN:0]    onset
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [NIN:0]    idx_q;
    logic [TT_W-1:0] tt_q;
    logic [TT_W-1:0] exp_q;
    logic            mismatch_q;
    logic            start_acc;
    logic            drive_vld;
    logic            cap_vld;
    logic [NIN-1:0]  cap_idx;
    logic            pipe_busy;

    assign start_acc = (state_q == S_IDLE) && start;
    // idx carries one extra bit so the end of the sweep is seen without wrapping
    assign drive_vld = (state_q == S_SWEEP) && !idx_q[NIN];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SWEEP;
            S_SWEEP: if (idx_q[NIN]) state_d = (LAT > 0) ? S_DRAIN : S_HOLD;
            S_DRAIN: if (!pipe_busy) state_d = S_HOLD;
            S_HOLD:  if (res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x_o = '0;
        if (state_q == S_SWEEP || state_q == S_DRAIN) begin
            x_o = idx_q[NIN] ? '1 : idx_q[NIN-1:0];
        end
    end

    generate
        if (LAT == 0) begin : g_comb
            assign cap_vld   = drive_vld;
            assign cap_idx   = idx_q[NIN-1:0];
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            // Minterm index travels alongside the function block's latency
            logic [LAT-1:0] vld_q;
            logic [NIN-1:0] pidx_q [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < LAT; i++) pidx_q[i] <= '0;
                end else begin
                    vld_q[0]  <= drive_vld;
                    pidx_q[0] <= idx_q[NIN-1:0];
                    for (int i = 1; i < LAT; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        pidx_q[i] <= pidx_q[i-1];
                    end
                end
            end

            assign cap_vld   = vld_q[LAT-1];
            assign cap_idx   = pidx_q[LAT-1];
            assign pipe_busy = |vld_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tt_q       <= '0;
            exp_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                idx_q      <= '0;
                tt_q       <= '0;
                exp_q      <= exp_tt;
                mismatch_q <= 1'b0;
            end else begin
                if (drive_vld) idx_q <= idx_q + {{NIN{1'b0}}, 1'b1};
                if (cap_vld) tt_q[cap_idx] <= f_i;
                // Table is complete by the time HOLD is entered
                if (state_q != S_HOLD && state_d == S_HOLD) mismatch_q <= (tt_q != exp_q);
            end
        end
    end

`ifdef TT_POPCOUNT_EN
    logic [NIN:0] onset_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onset_q <= '0;
        end else if (start_acc) begin
            onset_q <= '0;
        end else if (cap_vld && f_i) begin
            onset_q <= onset_q + {{NIN{1'b0}}, 1'b1};
        end
    end

    assign onset = onset_q;
`endif

    assign busy      = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    assign res_valid = (state_q == S_HOLD);
    assign tt        = tt_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Scoreboard bench for tt_sweep_capture: a LAT=0 and a LAT=2 instance swept in parallel.
module tb_tt_sweep_capture;

    localparam int NIN = 7;

    typedef struct {
        logic [127:0] tt;
        logic         mm;
        int           onset;
        int           stamp;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         res_ready = 1'b1;
    logic [127:0] exp_tt = '0;
    logic [127:0] rtt = '0;
    int           fsel = 0;
    int           cyc = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    logic         busy0, busy2, rv0, rv2, mm0, mm2, f0, f2;
    logic [6:0]   x0, x2, xd1, xd2;
    logic [127:0] tt0, tt2;
`ifdef TT_POPCOUNT_EN
    logic [7:0]   on0, on2;
`endif

    exp_t q0[$];
    exp_t q2[$];
    logic rv0_prev = 1'b0;
    logic rv2_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic fn(input int sel, input logic [6:0] m, input logic [127:0] r);
        case (sel)
            0: return 1'b0;
            1: return m[0] & m[1];
            2: return m[6];
            3: return (m[0] & m[3]) | (m[0] & m[4]) | (m[3] & m[4]);
            default: return r[m];
        endcase
    endfunction

    function automatic logic [127:0] model_tt(input int sel, input logic [127:0] r);
        logic [127:0] t;
        t = '0;
        for (int m = 0; m < 128; m++) t[m] = fn(sel, 7'(m), r);
        return t;
    endfunction

    // Function under test: combinational for dut0, two-cycle delayed for dut2
    assign f0 = fn(fsel, x0, rtt);
    always @(posedge clk) begin
        xd1 <= x2;
        xd2 <= xd1;
    end
    assign f2 = fn(fsel, xd2, rtt);

    tt_sweep_capture #(.NIN(NIN), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .x_o(x0), .f_i(f0),
        .exp_tt(exp_tt), .res_valid(rv0), .res_ready(res_ready), .tt(tt0), .mismatch(mm0)
`ifdef TT_POPCOUNT_EN
        , .onset(on0)
`endif
    );

    tt_sweep_capture #(.NIN(NIN), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy2), .x_o(x2), .f_i(f2),
        .exp_tt(exp_tt), .res_valid(rv2), .res_ready(res_ready), .tt(tt2), .mismatch(mm2)
`ifdef TT_POPCOUNT_EN
        , .onset(on2)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: result presented with no expectation queued", name);
    endtask

    // Monitor: pops the scoreboard when a result is first presented
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            rv0_prev = 1'b0;
            rv2_prev = 1'b0;
        end else begin
            if (rv0 && !rv0_prev) begin
                if (q0.size() == 0) unexpected("result0");
                else begin
                    e = q0.pop_front();
                    chk("tt0", tt0, e.tt);
                    chk("mismatch0", mm0, e.mm);
                    chk("latency0", cyc - e.stamp, 129);
`ifdef TT_POPCOUNT_EN
                    chk("onset0", on0, e.onset);
`endif
                end
            end
            if (rv2 && !rv2_prev) begin
                if (q2.size() == 0) unexpected("result2");
                else begin
                    e = q2.pop_front();
                    chk("tt2", tt2, e.tt);
                    chk("mismatch2", mm2, e.mm);
                    chk("latency2", cyc - e.stamp, 131);
`ifdef TT_POPCOUNT_EN
                    chk("onset2", on2, e.onset);
`endif
                end
            end
            rv0_prev = rv0;
            rv2_prev = rv2;
        end
    end

    task automatic run_sweep(input int sel, input logic [127:0] expv, input bit wait_done);
        exp_t e;
        @(negedge clk);
        fsel    = sel;
        e.tt    = model_tt(sel, rtt);
        e.mm    = (e.tt != expv);
        e.onset = $countones(e.tt);
        e.stamp = cyc + 1;
        q0.push_back(e);
        q2.push_back(e);
        start  = 1'b1;
        exp_tt = expv;
        @(negedge clk);
        start  = 1'b0;
        exp_tt = {$urandom, $urandom, $urandom, $urandom};
        chk("busy0_start", busy0, 1'b1);
        chk("busy2_start", busy2, 1'b1);
        chk("x0_first", x0, 7'd0);
        if (wait_done) begin
            for (int i = 0; i < 400 && (q0.size() != 0 || q2.size() != 0); i++) @(negedge clk);
            if (q0.size() != 0 || q2.size() != 0) begin
                unexpected("sweep_timeout");
                q0.delete();
                q2.delete();
            end
            repeat (2) @(negedge clk);
            chk("busy0_idle", busy0, 1'b0);
            chk("rv2_idle", rv2, 1'b0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy0"}, busy0, 1'b0);
        chk({tag, "_busy2"}, busy2, 1'b0);
        chk({tag, "_rv0"}, rv0, 1'b0);
        chk({tag, "_rv2"}, rv2, 1'b0);
        chk({tag, "_x0"}, x0, 7'd0);
        chk({tag, "_x2"}, x2, 7'd0);
        chk({tag, "_tt0"}, tt0, 128'd0);
        chk({tag, "_tt2"}, tt2, 128'd0);
        chk({tag, "_mm0"}, mm0, 1'b0);
        chk({tag, "_mm2"}, mm2, 1'b0);
`ifdef TT_POPCOUNT_EN
        chk({tag, "_on0"}, on0, 8'd0);
        chk({tag, "_on2"}, on2, 8'd0);
`endif
    endtask

    initial begin
        logic [127:0] m;
        logic [127:0] bp_tt;
        int           sel;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        run_sweep(0, '0, 1'b1);
        run_sweep(1, {32{4'h8}}, 1'b1);
        run_sweep(2, '0, 1'b1);
        run_sweep(3, model_tt(3, '0), 1'b1);
        chk("tt_and01_const", model_tt(1, '0), {32{4'h8}});

        for (int k = 0; k < 6; k++) begin
            rtt = {$urandom, $urandom, $urandom, $urandom};
            sel = $urandom_range(0, 4);
            m   = model_tt(sel, rtt);
            if ($urandom_range(0, 1) == 1) m[$urandom_range(0, 127)] ^= 1'b1;
            run_sweep(sel, m, 1'b1);
        end

        // Backpressure: result must stay put and start must be ignored
        rtt   = {$urandom, $urandom, $urandom, $urandom};
        bp_tt = model_tt(4, rtt);
        res_ready = 1'b0;
        run_sweep(4, bp_tt, 1'b0);
        for (int i = 0; i < 400 && !(rv0 && rv2); i++) @(negedge clk);
        chk("bp_valid_reached", rv0 && rv2, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = (i == 5);
            chk("bp_rv0", rv0, 1'b1);
            chk("bp_rv2", rv2, 1'b1);
            chk("bp_tt0", tt0, bp_tt);
            chk("bp_tt2", tt2, bp_tt);
            chk("bp_busy0", busy0, 1'b0);
        end
        start = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bp_done_rv0", rv0, 1'b0);
        chk("bp_done_rv2", rv2, 1'b0);
        chk("bp_done_busy0", busy0, 1'b0);
        chk("bp_done_busy2", busy2, 1'b0);
        chk("bp_keep_tt0", tt0, bp_tt);
        repeat (3) @(negedge clk);
        chk("bp_still_idle", busy0, 1'b0);
        rtt = {$urandom, $urandom, $urandom, $urandom};
        run_sweep(4, '0, 1'b1);

        // Reset in the middle of a sweep
        rtt = {$urandom, $urandom, $urandom, $urandom};
        run_sweep(4, '0, 1'b0);
        for (int i = 0; i < 200 && x0 != 7'd50; i++) @(negedge clk);
        chk("midreset_reached50", x0, 7'd50);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        q0.delete();
        q2.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(4, model_tt(4, rtt), 1'b1);
        run_sweep(2, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, time %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Sequential stimulus/capture stage that sits directly upstream and downstream of a combinational 7-input Boolean function block (x0..x6 -> out).
- On start, it drives all 2^NIN input minterms in ascending order and samples the function output for each one.
- It assembles the results into a 2^NIN-bit truth table and presents it through a valid/ready handshake, with a compare against an expected table.
- Used to produce the classification signature of each function netlist.

Parameters:
- NIN, 7, number of function inputs; truth-table width TT_W = 2**NIN.
- LAT, 0, pipeline delay in cycles between driving x_o and a valid f_i (0 = purely combinational DUT); legal range 0..3.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a sweep; accepted only in IDLE.
- busy  output  1  high in SWEEP and DRAIN.
- x_o  output  NIN  minterm driven to the function; bit i drives x<i>.
- f_i  input  1  function output (out) for the minterm driven LAT cycles earlier.
- exp_tt  input  TT_W  expected truth table; sampled when start is accepted.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- tt  output  TT_W  captured truth table; tt[m] = f(minterm m); MSB = minterm all-ones.
- mismatch  output  1  tt != captured exp_tt; valid while res_valid is high.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, x_o=0, busy=0, res_valid=0, tt=0, mismatch=0, internal counters=0. Takes effect immediately, including mid-sweep; the partial result is discarded.
- States: IDLE, SWEEP, DRAIN, HOLD.
- IDLE -> SWEEP: when start=1. Latch exp_tt, clear tt, set idx=0.
- SWEEP:
  - x_o=idx each cycle; idx increments by 1.
  - After x_o = 2^NIN-1 has been driven, go to DRAIN if LAT>0, otherwise go to HOLD.
  - idx is NIN+1 bits wide, so reaching 2^NIN is detected without wrap.
- Capture: a delayed copy of idx with a valid tag (LAT-stage shift) writes tt[idx_d] <= f_i. With LAT=0, the write happens in the same cycle x_o is driven.
- DRAIN:
  - Holds x_o at 2^NIN-1 for LAT cycles until the last sample is written.
  - Then goes to HOLD.
- HOLD:
  - res_valid=1; tt and mismatch are stable.
  - On res_valid & res_ready, res_valid drops next cycle and the state returns to IDLE.
  - tt keeps its value until the next accepted start.
- Latency: start accepted at edge 0 -> res_valid high after edge 2^NIN + LAT + 1 (129 cycles for the defaults).
- start is ignored in SWEEP, DRAIN and HOLD. If start and res_ready are both high in HOLD, the handshake completes and start is ignored; a new start is needed in IDLE.
- x_o returns to 0 on entry to IDLE.
- mismatch is computed registered on entry to HOLD from the full-width compare.
- f_i is sampled as-is; X/Z on f_i is the DUT's problem and is not filtered.

Optional Feature:
- Macro TT_POPCOUNT_EN.
- Defined:
  - Adds output port onset (NIN+1 bits): the number of minterms with f=1, accumulated incrementally at each capture write.
  - Cleared on reset and on start accept; valid in HOLD. Range is 0..2^NIN (128 for all-ones).
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- f_i tied 0, exp_tt=0 -> tt=0, mismatch=0, res_valid rises 129 cycles after start (LAT=0); onset=0 if enabled.
- f_i = x_o[0] & x_o[1], exp_tt=0x8888...8 (32 hex digits) -> tt=0x8888...8, mismatch=0; onset=32.
- f_i = x_o[6], exp_tt=0 -> tt = 64 ones in the upper half and 64 zeros in the lower half, mismatch=1; onset=64.
- LAT=2 with f_i = maj(x0,x3,x4) delayed two cycles -> tt equals the LAT=0 capture of the same function; res_valid rises at cycle 131.
- Backpressure: hold res_ready=0 for 20 cycles and pulse start during HOLD -> res_valid and tt stay stable, start is ignored; after res_ready=1, return to IDLE, and a new start gives a fresh sweep.
- rst_n asserted at idx=50 -> all outputs 0 immediately; after release, a start yields a complete and correct table.
